// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment capture path.
//
// Contents:
//   SEG_W        - number of segment lines (a..g)
//   CNT_W        - width of the stability counter (enough for counts up to 15)
//   SEG7_CODES   - the 16 legal segment codes, index = hex value, {a,b,c,d,e,f,g}
//   seg7_entry_t - one stored digit: decoded value, legal flag, captured dot
//   seg7_dec_t   - decoder result {legal, value}
//   seg7_decode  - segment pattern -> {legal, value}; unknown patterns give 0/illegal
//   seg7_encode  - hex value -> segment pattern (the encoder side uses this table too)
package seg7_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned NUM_CODES = 16;

    localparam logic [SEG_W-1:0] SEG7_CODES [NUM_CODES] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // B
        7'b1001110,  // C
        7'b0111101,  // D
        7'b1001111,  // E
        7'b1000111   // F
    };

    typedef struct packed {
        logic [3:0] value;
        logic       legal;
        logic       dot;
    } seg7_entry_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg7_dec_t;

    // Linear match against the table; the codes are distinct, so at most one hits.
    function automatic seg7_dec_t seg7_decode(input logic [SEG_W-1:0] seg);
        seg7_dec_t res;
        res = '0;
        for (int i = 0; i < int'(NUM_CODES); i++) begin
            if (seg == SEG7_CODES[i]) begin
                res.legal = 1'b1;
                res.value = 4'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] value);
        return SEG7_CODES[value];
    endfunction

endpackage

// File: rtl/seg7_stab.sv
// seg7_stab: input synchroniser and pattern-stability tracker.
//
// The raw display bus {seg, dot, digit strobe} is passed through two flops.
// The synchronised sample is compared with the previous one every cycle; a run
// of identical samples with an exactly one-hot strobe is counted up to
// STABLE_CNT. accept_o pulses (combinationally, for the edge on which the count
// goes STABLE_CNT-1 -> STABLE_CNT) once per stable window.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   seg_i     - raw segment lines {a..g}
//   dot_i     - raw decimal point (tie 0 to keep it out of the compare)
//   sel_i     - raw one-hot digit strobe
//   accept_o  - stable pattern accepted on this edge
//   idx_o     - index of the strobed digit in the synchronised sample
//   seg_o     - synchronised segment pattern
//   dot_o     - synchronised dot
module seg7_stab
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      seg_i,
    input  logic                  dot_i,
    input  logic [NUM_DIGITS-1:0] sel_i,
    output logic                  accept_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  dot_o
);

    localparam int unsigned PAT_W = SEG_W + 1 + NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    // Sample layout: {seg, dot, sel}
    logic [PAT_W-1:0]      sync1_q, sync2_q, last_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] s_sel;
    logic                  one_hot;
    logic                  same;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {seg_i, dot_i, sel_i};
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign s_sel   = sync2_q[NUM_DIGITS-1:0];
    assign one_hot = (s_sel != '0) && ((s_sel & (s_sel - NUM_DIGITS'(1))) == '0);
    assign same    = (sync2_q == last_q);
    assign seg_o   = sync2_q[PAT_W-1 -: SEG_W];
    assign dot_o   = sync2_q[NUM_DIGITS];

    // Count saturates at STABLE_CNT so a long-held pattern accepts only once.
    always_comb begin
        cnt_d    = '0;
        accept_o = 1'b0;
        if (one_hot) begin
            if (same) begin
                cnt_d    = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                accept_o = (cnt_q == CNT_MAX - CNT_W'(1));
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    // Only meaningful when the strobe is one-hot; accept_o is low otherwise.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (s_sel[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: recovers hex digit values from a multiplexed 7-segment bus.
//
// A digit's pattern is accepted once it has been stable for STABLE_CNT
// synchronised samples. Accepted values are decoded and stored per digit; any
// change (or the first capture of a digit since reset) is reported through a
// one-entry valid/ready event register. An event arriving while the register
// is full and not being drained is dropped and flagged by a one-cycle ovf
// pulse; storage is updated regardless.
//
// Build option:
//   SEG7_CAP_DOT_EN - when defined, dot_in is synchronised, takes part in the
//                     stability and change compares and is reported on
//                     out_dot. Otherwise dot_in is ignored and out_dot is 0.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   seg_in     - segment lines {a,b,c,d,e,f,g}, 1 = lit
//   dot_in     - decimal point, 1 = lit
//   digit_sel  - one-hot digit strobe
//   out_valid  - change event pending
//   out_ready  - consumer takes the event when out_valid && out_ready
//   out_idx    - digit index of the event
//   out_value  - decoded hex value of the event
//   out_legal  - pattern was a legal code
//   out_dot    - captured dot of the event
//   digits     - stored values, digit i at [4i+3:4i]
//   legal      - per-digit legal flag
//   ovf        - one-cycle pulse when an event was dropped
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEG_W-1:0]              seg_in,
    input  logic                          dot_in,
    input  logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_DIGITS)-1:0] out_idx,
    output logic [3:0]                    out_value,
    output logic                          out_legal,
    output logic                          out_dot,
    output logic [4*NUM_DIGITS-1:0]       digits,
    output logic [NUM_DIGITS-1:0]         legal,
    output logic                          ovf
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic dot_eff;

`ifdef SEG7_CAP_DOT_EN
    assign dot_eff = dot_in;
`else
    logic unused_dot;
    assign unused_dot = dot_in;
    assign dot_eff    = 1'b0;
`endif

    logic             st_accept;
    logic [IDX_W-1:0] st_idx;
    logic [SEG_W-1:0] st_seg;
    logic             st_dot;

    seg7_stab #(
        .NUM_DIGITS (NUM_DIGITS),
        .STABLE_CNT (STABLE_CNT),
        .IDX_W      (IDX_W)
    ) u_stab (
        .clk      (clk),
        .rst      (rst),
        .seg_i    (seg_in),
        .dot_i    (dot_eff),
        .sel_i    (digit_sel),
        .accept_o (st_accept),
        .idx_o    (st_idx),
        .seg_o    (st_seg),
        .dot_o    (st_dot)
    );

    seg7_dec_t   dec;
    seg7_entry_t new_entry;
    logic        changed;
    logic        new_event;

    seg7_entry_t           store_q [NUM_DIGITS];
    seg7_entry_t           store_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic                  out_valid_q, out_valid_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    seg7_entry_t           out_ent_q, out_ent_d;
    logic                  ovf_q, ovf_d;

    assign dec       = seg7_decode(st_seg);
    assign new_entry = '{value: dec.value, legal: dec.legal, dot: st_dot};

    // A never-captured digit always reports, even if it decodes to the reset
    // contents (blank -> value 0, illegal).
    assign changed   = !seen_q[st_idx] || (store_q[st_idx] != new_entry);
    assign new_event = st_accept && changed;

    always_comb begin
        store_d     = store_q;
        seen_d      = seen_q;
        out_valid_d = out_valid_q && !out_ready;
        out_idx_d   = out_idx_q;
        out_ent_d   = out_ent_q;
        ovf_d       = 1'b0;
        if (new_event) begin
            store_d[st_idx] = new_entry;
            seen_d[st_idx]  = 1'b1;
            // Slot is free if empty or being drained on this same edge.
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_idx_d   = st_idx;
                out_ent_d   = new_entry;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q     <= '{default: '0};
            seen_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_ent_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            store_q     <= store_d;
            seen_q      <= seen_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_ent_q   <= out_ent_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        digits = '0;
        legal  = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            digits[4*i +: 4] = store_q[i].value;
            legal[i]         = store_q[i].legal;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_value = out_ent_q.value;
    assign out_legal = out_ent_q.legal;
    assign out_dot   = out_ent_q.dot;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture (default parameters).
// A reference model reacting on every rising edge predicts the outputs from
// the history of applied inputs; directed table vectors and hand sequences add
// constant-expectation checks for latency, overflow, strobe errors and reset.
module tb_seg7_capture;

    localparam int N = 4;
    localparam int S = 4;

`ifdef SEG7_CAP_DOT_EN
    localparam bit DOT_EN = 1'b1;
`else
    localparam bit DOT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [6:0]     seg_in = '0;
    logic           dot_in = 1'b0;
    logic [N-1:0]   digit_sel = '0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [1:0]     out_idx;
    logic [3:0]     out_value;
    logic           out_legal;
    logic           out_dot;
    logic [4*N-1:0] digits;
    logic [N-1:0]   legal;
    logic           ovf;

    always #5 clk = ~clk;

    seg7_capture #(
        .NUM_DIGITS (N),
        .STABLE_CNT (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dot_in    (dot_in),
        .digit_sel (digit_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_value (out_value),
        .out_legal (out_legal),
        .out_dot   (out_dot),
        .digits    (digits),
        .legal     (legal),
        .ovf       (ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    localparam logic [6:0] CODES [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (CODES[i] == s) return {1'b1, 4'(i)};
        end
        return 5'b0;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [N-1:0] sel;
        logic [6:0]   seg;
        logic         dot;
    } samp_t;

    samp_t hist[$];      // inputs seen at each rising edge since reset
    int    m_val [N];
    bit    m_leg [N];
    bit    m_dot [N];
    bit    m_seen[N];
    bit    e_valid, e_leg, e_dot, e_ovf;
    int    e_idx, e_val;

    // Length of the run of identical samples ending at the sample the design
    // evaluates on this edge (two edges of synchroniser delay).
    function automatic int run_len();
        int    n;
        int    len;
        int    j;
        samp_t p;
        n = hist.size();
        if (n < 3) return 0;
        p = hist[n-3];
        if ($countones(p.sel) != 1) return 0;
        len = 1;
        j   = n - 4;
        while (j >= 0 && len <= S && hist[j] == p) begin
            len++;
            j--;
        end
        return len;
    endfunction

    samp_t       cur, acc;
    int          ix;
    bit          newev;
    logic [4:0]  d;
    logic [15:0] exp_digits;
    logic [N-1:0] exp_legal;

    always @(posedge clk) begin
        cur   = '{sel: digit_sel, seg: seg_in, dot: DOT_EN ? dot_in : 1'b0};
        e_ovf = 1'b0;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < N; k++) begin
                m_val[k] = 0; m_leg[k] = 0; m_dot[k] = 0; m_seen[k] = 0;
            end
            e_valid = 0; e_idx = 0; e_val = 0; e_leg = 0; e_dot = 0;
        end else begin
            hist.push_back(cur);
            if (hist.size() > 24) void'(hist.pop_front());
            newev = 1'b0;
            if (run_len() == S) begin
                acc = hist[hist.size()-3];
                ix  = 0;
                for (int k = 0; k < N; k++) if (acc.sel[k]) ix = k;
                d = ref_decode(acc.seg);
                if (!m_seen[ix] || m_val[ix] != int'(d[3:0]) || m_leg[ix] != d[4]
                    || m_dot[ix] != acc.dot) begin
                    newev      = 1'b1;
                    m_seen[ix] = 1'b1;
                    m_val[ix]  = int'(d[3:0]);
                    m_leg[ix]  = d[4];
                    m_dot[ix]  = acc.dot;
                end
            end
            if (e_valid && out_ready) e_valid = 1'b0;
            if (newev) begin
                if (!e_valid) begin
                    e_valid = 1'b1; e_idx = ix; e_val = int'(d[3:0]);
                    e_leg = d[4]; e_dot = acc.dot;
                end else begin
                    e_ovf = 1'b1;
                end
            end
        end
        #1;
        for (int k = 0; k < N; k++) begin
            exp_digits[4*k +: 4] = 4'(m_val[k]);
            exp_legal[k]         = m_leg[k];
        end
        chk("model_valid", out_valid, e_valid);
        if (e_valid) begin
            chk("model_idx", out_idx, e_idx);
            chk("model_value", out_value, e_val);
            chk("model_legal", out_legal, e_leg);
            chk("model_dot", out_dot, e_dot);
        end
        chk("model_ovf", ovf, e_ovf);
        chk("model_digits", digits, exp_digits);
        chk("model_legalvec", legal, exp_legal);
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [N-1:0] sel;
        logic [6:0]   seg;
        int           hold;
        bit           ev;
        int           idx;
        int           val;
        bit           leg;
    } vec_t;

    vec_t vt[9];
    int   npulse;
    int   r;
    int   hold;

    initial begin
        vt[0] = '{4'b0100, 7'b1111001, 8, 1, 2, 3,  1};  // digit 2 -> 3
        vt[1] = '{4'b0010, 7'b0000000, 8, 1, 1, 0,  0};  // blank -> illegal 0
        vt[2] = '{4'b1000, 7'b1011011, 3, 0, 0, 0,  0};  // too short
        vt[3] = '{4'b0100, 7'b1111001, 8, 0, 0, 0,  0};  // re-shown, unchanged
        vt[4] = '{4'b0100, 7'b1000111, 8, 1, 2, 15, 1};  // change to F
        vt[5] = '{4'b0011, 7'b1111111, 8, 0, 0, 0,  0};  // two strobes
        vt[6] = '{4'b1000, 7'b1110111, 8, 1, 3, 10, 1};  // A
        vt[7] = '{4'b1000, 7'b1110111, 8, 0, 0, 0,  0};  // same again
        vt[8] = '{4'b0001, 7'b0111101, 8, 1, 0, 13, 1};  // D over stored 2

        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", out_valid, 0);
        chk("reset_digits", digits, 0);
        chk("reset_legal", legal, 0);
        @(negedge clk) rst = 1'b0;

        // Latency: drive before edge 1, event visible after edge 6.
        @(negedge clk);
        digit_sel = 4'b0001; seg_in = 7'b1101101; out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 chk("lat_edge5", out_valid, 0);
        @(posedge clk);
        #2;
        chk("lat_edge6", out_valid, 1);
        chk("lat_idx", out_idx, 0);
        chk("lat_value", out_value, 2);
        chk("lat_legal", out_legal, 1);
        repeat (4) @(posedge clk);
        #2 chk("lat_digit0", digits[3:0], 2);
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("no_refire", out_valid, 0);

        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            digit_sel = vt[v].sel; seg_in = vt[v].seg; out_ready = 1'b0;
            repeat (vt[v].hold) @(posedge clk);
            #2;
            chk("vec_valid", out_valid, vt[v].ev);
            if (vt[v].ev) begin
                chk("vec_idx", out_idx, vt[v].idx);
                chk("vec_value", out_value, vt[v].val);
                chk("vec_legal", out_legal, vt[v].leg);
                @(negedge clk) out_ready = 1'b1;
            end
        end
        #2;
        chk("table_digits", digits, 16'hAF0D);
        chk("table_legal", legal, 4'b1101);

        // Short hold then change: count restarts at 1.
        @(negedge clk);
        digit_sel = 4'b1000; seg_in = 7'b1011011; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) seg_in = 7'b1011111;
        repeat (3) @(posedge clk);
        #2;
        chk("restart_cnt", dut.u_stab.cnt_q, 1);
        chk("restart_valid", out_valid, 0);

        // Overflow: first event held, second dropped.
        @(negedge clk);
        digit_sel = 4'b0010; seg_in = 7'b0110000;
        repeat (8) @(posedge clk);
        #2 chk("ovf_first_valid", out_valid, 1);
        @(negedge clk);
        digit_sel = 4'b1000; seg_in = 7'b1111111;
        npulse = 0;
        repeat (8) begin
            @(posedge clk);
            #2 if (ovf) npulse++;
        end
        chk("ovf_pulses", npulse, 1);
        chk("ovf_hold_idx", out_idx, 1);
        chk("ovf_hold_value", out_value, 1);
        chk("ovf_digits", digits, 16'h8F1D);
        chk("ovf_legal", legal, 4'b1111);
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;

        // Two strobe bits: count stays 0, nothing reported.
        @(negedge clk);
        digit_sel = 4'b0011; seg_in = 7'b1111110;
        repeat (6) @(posedge clk);
        #2;
        chk("multi_cnt", dut.u_stab.cnt_q, 0);
        chk("multi_valid", out_valid, 0);

        // Reset with an event pending, then first capture must report.
        @(negedge clk);
        digit_sel = 4'b0100; seg_in = 7'b1111110;
        repeat (8) @(posedge clk);
        #2 chk("pre_rst_valid", out_valid, 1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_digits", digits, 0);
        chk("rst_legal", legal, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        digit_sel = 4'b0001; seg_in = 7'b0000000;
        repeat (8) @(posedge clk);
        #2;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_idx", out_idx, 0);
        chk("post_rst_value", out_value, 0);
        chk("post_rst_legal", out_legal, 0);
        @(negedge clk) out_ready = 1'b1;

        // Randomised traffic, checked by the model every cycle.
        for (int s = 0; s < 400; s++) begin
            logic [N-1:0] rs;
            logic [6:0]   rg;
            logic         rd;
            r = $urandom_range(0, 99);
            if (r < 85) rs = N'(1) << $urandom_range(0, N-1);
            else        rs = N'($urandom);
            r = $urandom_range(0, 99);
            if (r < 70)      rg = CODES[$urandom_range(0, 15)];
            else if (r < 80) rg = 7'b0;
            else             rg = 7'($urandom);
            rd   = 1'($urandom);
            hold = $urandom_range(1, 9);
            repeat (hold) begin
                @(negedge clk);
                digit_sel = rs; seg_in = rg; dot_in = rd;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk) out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
